// File: rtl/stream_mux_rr_pkg.sv
// Shared types and helpers for the round-robin / fixed-priority stream multiplexer.
package stream_mux_pkg;

   typedef enum logic {
      ARB  = 1'b0,
      LOCK = 1'b1
   } state_t;

   localparam int MODE_FIXED = 0;
   localparam int MODE_RR    = 1;

   // Channel-index width: never narrower than one bit, even for N = 2.
   function automatic int sel_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/stream_mux_rr_if.sv
// Bundle of the N input streams and the single output stream of stream_mux_rr.
interface stream_mux_rr_if
   import stream_mux_pkg::*;
#(
   parameter int N = 4,
   parameter int W = 8
);
   localparam int SEL_W = sel_w(N);

   // Handshake: a beat moves on a channel in any cycle where valid and ready are both 1
   // at the rising edge; valid never waits for ready, and ready may depend on valid.
   logic [N*W-1:0]   in_data;
   logic [N-1:0]     in_valid;
   logic [N-1:0]     in_last;
   logic [N-1:0]     in_ready;
   logic [W-1:0]     out_data;
   logic             out_valid;
   logic             out_last;
   logic [SEL_W-1:0] out_sel;
   logic             out_ready;

   modport master (
      output in_data, in_valid, in_last, out_ready,
      input  in_ready, out_data, out_valid, out_last, out_sel
   );

   modport slave (
      input  in_data, in_valid, in_last, out_ready,
      output in_ready, out_data, out_valid, out_last, out_sel
   );

endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational arbiter: lowest index first (fixed) or first request at/after rr_ptr (round-robin).
module rr_arbiter
   import stream_mux_pkg::*;
#(
   parameter  int N     = 4,
   parameter  int MODE  = MODE_RR,
   localparam int SEL_W = sel_w(N)
) (
   input  logic [N-1:0]     req,
   input  logic [SEL_W-1:0] rr_ptr,
   output logic [N-1:0]     gnt,
   output logic [SEL_W-1:0] gnt_idx,
   output logic             any
);

   int c;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      c       = 0;
      for (int k = 0; k < N; k++) begin
         if (MODE == MODE_RR) begin
            c = int'(rr_ptr) + k;
            if (c >= N) c = c - N;
         end else begin
            c = k;
         end
         if (!any && req[c]) begin
            any     = 1'b1;
            gnt[c]  = 1'b1;
            gnt_idx = SEL_W'(c);
         end
      end
   end

endmodule

// File: rtl/stream_mux_rr.sv
// N-input stream mux: arbitrates per packet, locks the winner until its last beat, registered output.
module stream_mux_rr
   import stream_mux_pkg::*;
#(
   parameter  int N     = 4,
   parameter  int W     = 8,
   parameter  int MODE  = MODE_RR,
   localparam int SEL_W = sel_w(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   stream_mux_rr_if.slave   bus,
   output state_t           dbg_state,
   output logic [SEL_W-1:0] dbg_rr_ptr
);

   state_t           state;
   logic [SEL_W-1:0] lock_ch;
   logic [SEL_W-1:0] rr_ptr;
   logic [N-1:0]     gnt;
   logic [SEL_W-1:0] gnt_idx;
   logic             any;
   logic             load;
   logic             xfer;
   logic [N-1:0]     ready;
   logic [SEL_W-1:0] src_ch;
   logic [W-1:0]     src_data;
   logic             src_last;
   logic [SEL_W-1:0] next_ptr;

   rr_arbiter #(.N(N), .MODE(MODE)) u_arb (
      .req     (bus.in_valid),
      .rr_ptr  (rr_ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .any     (any)
   );

   assign load = !bus.out_valid || bus.out_ready;

   // While locked the arbiter result is ignored; the locked channel alone may be ready.
   always_comb begin
      ready  = '0;
      src_ch = (state == LOCK) ? lock_ch : gnt_idx;
      if (rst_n && load) begin
         if (state == LOCK) begin
            for (int i = 0; i < N; i++)
               if (i == int'(lock_ch)) ready[i] = 1'b1;
         end else if (any) begin
            ready = gnt;
         end
      end
   end

   assign bus.in_ready = ready;
   assign xfer         = |(ready & bus.in_valid);

   always_comb begin
      src_data = '0;
      src_last = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (i == int'(src_ch)) begin
            src_data = bus.in_data[i*W +: W];
            src_last = bus.in_last[i];
         end
      end
   end

   always_comb begin
      if (int'(src_ch) == N - 1) next_ptr = '0;
      else                       next_ptr = src_ch + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ARB;
         lock_ch       <= '0;
         rr_ptr        <= '0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_last  <= 1'b0;
         bus.out_sel   <= '0;
      end else if (load) begin
         bus.out_valid <= xfer;
         if (xfer) begin
            bus.out_data <= src_data;
            bus.out_last <= src_last;
            bus.out_sel  <= src_ch;
            case (state)
               ARB: begin
                  if (!src_last) begin
                     state   <= LOCK;
                     lock_ch <= src_ch;
                  end else begin
                     rr_ptr  <= next_ptr;
                  end
               end
               LOCK: begin
                  if (src_last) begin
                     state  <= ARB;
                     rr_ptr <= next_ptr;
                  end
               end
               default: state <= ARB;
            endcase
         end
      end
   end

   assign dbg_state  = state;
   assign dbg_rr_ptr = rr_ptr;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: directed scenarios plus random traffic against a packet-level model.
module tb_stream_mux_rr;
   import stream_mux_pkg::*;

   localparam int N     = 4;
   localparam int W     = 8;
   localparam int SEL_W = sel_w(N);
   localparam int BW    = SEL_W + 1 + W;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rst_drive = 1'b0;
   always #5 clk = ~clk;

   // stimulus drive shared by both instances; act selects which one sees traffic
   logic           act = 1'b0;
   logic [N*W-1:0] tb_data = '0;
   logic [N-1:0]   tb_valid = '0;
   logic [N-1:0]   tb_last = '0;
   logic           tb_out_ready = 1'b1;

   stream_mux_rr_if #(.N(N), .W(W)) bus_rr ();
   stream_mux_rr_if #(.N(N), .W(W)) bus_fx ();

   assign bus_rr.in_data   = tb_data;
   assign bus_rr.in_last   = tb_last;
   assign bus_rr.in_valid  = act ? '0 : tb_valid;
   assign bus_rr.out_ready = act ? 1'b1 : tb_out_ready;
   assign bus_fx.in_data   = tb_data;
   assign bus_fx.in_last   = tb_last;
   assign bus_fx.in_valid  = act ? tb_valid : '0;
   assign bus_fx.out_ready = act ? tb_out_ready : 1'b1;

   state_t           dbg_state_rr, dbg_state_fx;
   logic [SEL_W-1:0] dbg_ptr_rr, dbg_ptr_fx;

   stream_mux_rr #(.N(N), .W(W), .MODE(MODE_RR)) u_rr (
      .clk (clk), .rst_n (rst_n), .bus (bus_rr),
      .dbg_state (dbg_state_rr), .dbg_rr_ptr (dbg_ptr_rr)
   );

   stream_mux_rr #(.N(N), .W(W), .MODE(MODE_FIXED)) u_fx (
      .clk (clk), .rst_n (rst_n), .bus (bus_fx),
      .dbg_state (dbg_state_fx), .dbg_rr_ptr (dbg_ptr_fx)
   );

   logic [N-1:0]     o_ready;
   logic [W-1:0]     o_data;
   logic             o_valid, o_last, a_state;
   logic [SEL_W-1:0] o_sel, a_ptr;
   assign o_ready = act ? bus_fx.in_ready  : bus_rr.in_ready;
   assign o_data  = act ? bus_fx.out_data  : bus_rr.out_data;
   assign o_valid = act ? bus_fx.out_valid : bus_rr.out_valid;
   assign o_last  = act ? bus_fx.out_last  : bus_rr.out_last;
   assign o_sel   = act ? bus_fx.out_sel   : bus_rr.out_sel;
   assign a_state = act ? dbg_state_fx     : dbg_state_rr;
   assign a_ptr   = act ? dbg_ptr_fx       : dbg_ptr_rr;

   // per-channel source queues: {last, data}
   logic [W:0] src_mem [N][256];
   int         src_hd [N];
   int         src_tl [N];
   int         vprob = 100;
   int         rprob = 100;
   logic       bp = 1'b0;

   // reference model: packet-level arbitration state and the beat the output should hold
   logic [BW-1:0] exp_q[$];
   logic          m_ov = 1'b0;
   logic          m_locked = 1'b0;
   int            m_lock = 0;
   int            m_ptr = 0;

   // capture of beats leaving the output
   logic [SEL_W-1:0] cap_sel [64];
   logic [W-1:0]     cap_data [64];
   int               cap_n = 0;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int winner(input logic [N-1:0] v);
      int c;
      for (int k = 0; k < N; k++) begin
         c = act ? k : (m_ptr + k) % N;
         if (v[c]) return c;
      end
      return -1;
   endfunction

   function automatic logic busy();
      logic b;
      b = m_ov || (exp_q.size() != 0);
      for (int c = 0; c < N; c++) if (src_hd[c] != src_tl[c]) b = 1'b1;
      return b;
   endfunction

   task automatic push_beat(input int c, input logic [W-1:0] d, input logic l);
      src_mem[c][src_tl[c]] = {l, d};
      src_tl[c]++;
   endtask

   task automatic push_rand_pkt(input int c);
      int len;
      len = $urandom_range(1, 4);
      for (int j = 0; j < len; j++) push_beat(c, W'($urandom), j == len - 1);
   endtask

   task automatic clear_src();
      for (int c = 0; c < N; c++) begin
         src_hd[c] = 0;
         src_tl[c] = 0;
      end
   endtask

   // driver + model step: drive at negedge, check at negedge+1, advance model at posedge
   task automatic tick();
      int         g;
      logic [N-1:0] exp_ready;
      logic       load, xfer;
      logic [W:0] b;
      @(negedge clk);
      rst_n = rst_drive;
      for (int c = 0; c < N; c++) begin
         if (src_hd[c] != src_tl[c] && $urandom_range(0, 99) < vprob) begin
            b = src_mem[c][src_hd[c]];
            tb_valid[c] = 1'b1;
            tb_last[c] = b[W];
            tb_data[c*W +: W] = b[W-1:0];
         end else begin
            tb_valid[c] = 1'b0;
            tb_last[c] = 1'($urandom);
            tb_data[c*W +: W] = W'($urandom);
         end
      end
      tb_out_ready = bp ? 1'b0 : ($urandom_range(0, 99) < rprob);
      #1;
      if (!rst_n) begin
         m_ov = 1'b0; m_locked = 1'b0; m_lock = 0; m_ptr = 0;
         exp_q.delete();
      end
      exp_ready = '0;
      g = -1;
      load = !m_ov || tb_out_ready;
      if (rst_n && load) begin
         g = m_locked ? m_lock : winner(tb_valid);
         if (g >= 0) exp_ready[g] = 1'b1;
      end
      xfer = (g >= 0) && tb_valid[g];
      chk("in_ready", 32'(o_ready), 32'(exp_ready));
      chk("out_valid", 32'(o_valid), 32'(m_ov));
      chk("rr_ptr", 32'(a_ptr), 32'(m_ptr));
      chk("state", 32'(a_state), 32'(m_locked));
      if (m_ov) chk("out_beat", 32'({o_sel, o_last, o_data}), 32'(exp_q[0]));
      if (!rst_n) chk("reset_out", 32'({o_sel, o_last, o_data}), 32'(0));
      if (o_valid && tb_out_ready && cap_n < 64) begin
         cap_sel[cap_n] = o_sel;
         cap_data[cap_n] = o_data;
         cap_n++;
      end
      @(posedge clk);
      if (rst_n) begin
         if (m_ov && tb_out_ready) void'(exp_q.pop_front());
         if (load) begin
            m_ov = xfer;
            if (xfer) begin
               exp_q.push_back({SEL_W'(g), tb_last[g], tb_data[g*W +: W]});
               src_hd[g]++;
               if (tb_last[g]) begin
                  m_locked = 1'b0;
                  m_ptr = (g + 1) % N;
               end else begin
                  m_locked = 1'b1;
                  m_lock = g;
               end
            end
         end
      end
   endtask

   task automatic drain();
      int budget;
      vprob = 100;
      rprob = 100;
      budget = 0;
      while (busy() && budget < 500) begin
         tick();
         budget++;
      end
      chk("drain_done", 32'(busy()), 32'(0));
   endtask

   task automatic do_reset(input logic fixed);
      rst_drive = 1'b0;
      clear_src();
      tick();
      tick();
      act = fixed;
      rst_drive = 1'b1;
   endtask

   initial begin
      clear_src();
      do_reset(1'b0);

      // round-robin fairness: single-beat packets on all channels
      cap_n = 0;
      for (int j = 0; j < 6; j++)
         for (int c = 0; c < N; c++) push_beat(c, W'(8'h10 * c + j), 1'b1);
      drain();
      chk("rr_count", 32'(cap_n), 32'(24));
      for (int i = 0; i < 24; i++) chk("rr_order", 32'(cap_sel[i]), 32'(i % N));

      // packet lock: ch2 3-beat packet, ch0 requesting meanwhile
      cap_n = 0;
      push_beat(2, 8'hA1, 1'b0);
      push_beat(2, 8'hA2, 1'b0);
      push_beat(2, 8'hA3, 1'b1);
      tick();
      push_beat(0, 8'h01, 1'b1);
      push_beat(0, 8'h02, 1'b1);
      drain();
      chk("lock_d0", 32'({cap_sel[0], cap_data[0]}), 32'({2'd2, 8'hA1}));
      chk("lock_d1", 32'({cap_sel[1], cap_data[1]}), 32'({2'd2, 8'hA2}));
      chk("lock_d2", 32'({cap_sel[2], cap_data[2]}), 32'({2'd2, 8'hA3}));
      chk("lock_next", 32'(cap_sel[3]), 32'(0));

      // backpressure: hold 0x5C for 5 cycles
      cap_n = 0;
      push_beat(1, 8'h5C, 1'b1);
      push_beat(1, 8'h5D, 1'b1);
      tick();
      bp = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         #1;
         chk("bp_data", 32'({o_valid, o_data}), 32'({1'b1, 8'h5C}));
      end
      bp = 1'b0;
      drain();
      chk("bp_count", 32'(cap_n), 32'(2));
      chk("bp_first", 32'(cap_data[0]), 32'(8'h5C));
      chk("bp_second", 32'(cap_data[1]), 32'(8'h5D));

      // wrap-around: bring pointer to 3, then ch3 and ch0 compete
      push_beat(2, 8'h22, 1'b1);
      drain();
      cap_n = 0;
      push_beat(3, 8'h33, 1'b1);
      push_beat(0, 8'h30, 1'b1);
      drain();
      chk("wrap_first", 32'(cap_sel[0]), 32'(3));
      chk("wrap_second", 32'(cap_sel[1]), 32'(0));

      // reset in the middle of a locked ch1 packet
      for (int j = 0; j < 4; j++) push_beat(1, W'(8'h40 + j), j == 3);
      tick();
      tick();
      do_reset(1'b0);
      chk("rst_mid_ready", 32'(o_ready), 32'(0));
      cap_n = 0;
      push_beat(3, 8'h77, 1'b1);
      drain();
      chk("rst_after", 32'({cap_sel[0], cap_data[0]}), 32'({2'd3, 8'h77}));

      // random traffic, round-robin instance
      for (int p = 0; p < 6; p++)
         for (int c = 0; c < N; c++) push_rand_pkt(c);
      vprob = 70;
      rprob = 70;
      for (int i = 0; i < 300; i++) tick();
      drain();

      // fixed priority instance: ch1 beats ch3 while it has data
      do_reset(1'b1);
      cap_n = 0;
      for (int j = 0; j < 3; j++) push_beat(1, W'(8'h50 + j), 1'b1);
      push_beat(1, 8'h58, 1'b0);
      push_beat(1, 8'h59, 1'b1);
      for (int j = 0; j < 3; j++) push_beat(3, W'(8'h70 + j), 1'b1);
      drain();
      for (int i = 0; i < 5; i++) chk("fix_ch1", 32'(cap_sel[i]), 32'(1));
      for (int i = 5; i < 8; i++) chk("fix_ch3", 32'(cap_sel[i]), 32'(3));

      // random traffic, fixed instance
      for (int p = 0; p < 5; p++)
         for (int c = 0; c < N; c++) push_rand_pkt(c);
      vprob = 60;
      rprob = 75;
      for (int i = 0; i < 200; i++) tick();
      drain();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-input stream multiplexer with per-channel valid/ready handshakes, packet locking and a registered output stage. It generalises the 4:1 select-line mux into a clocked arbiter: instead of external select inputs, an internal fixed-priority or round-robin arbiter chooses the channel and holds it for a whole packet. The block sits between N packet sources and one shared downstream sink.

## Interface
- `N`, default 4: number of input channels, ≥2.
- `W`, default 8: data width per channel.
- `MODE`, default 1: 0 = fixed priority (channel 0 highest); 1 = round-robin.
- `clk` input, 1 bit: clock, rising edge.
- `rst_n` input, 1 bit: reset. One clock; reset is asynchronous and active-low.
- `in_data` input, N*W bits: channel i occupies bits [i*W +: W].
- `in_valid` input, N bits: per-channel beat valid.
- `in_last` input, N bits: per-channel end-of-packet marker, qualified by `in_valid`.
- `in_ready` output, N bits: per-channel accept.
- `out_data` output, W bits: registered data.
- `out_valid` output, 1 bit: registered valid.
- `out_last` output, 1 bit: registered end-of-packet.
- `out_sel` output, SEL_W = max(1, clog2(N)) bits: source channel of the current output beat.
- `out_ready` input, 1 bit: downstream accept.

## Operation
- Transfer on input i: `in_valid[i] && in_ready[i]`. Transfer on output: `out_valid && out_ready`.
- `load = !out_valid || out_ready`. The output register accepts a new beat only when `load` is 1.
- States:
  - ARB: no packet is in progress. When `load` and any `in_valid`, the arbiter picks winner g. `in_ready[g]=1` and all other ready bits are 0. The beat is registered. If `in_last[g]=0`, go to LOCK with `lock_ch=g`; otherwise stay in ARB. If no valid input, or `!load`, all `in_ready`=0.
  - LOCK: `in_ready[lock_ch] = load`; all others are 0. No re-arbitration. On transfer with `in_last=1`, go to ARB.
- Round-robin: the pointer `rr_ptr` gives the first channel searched, ascending with wrap N-1→0. When a packet's last beat transfers from channel g, `rr_ptr ← (g+1) mod N`, so N-1 wraps to 0. Fixed mode ignores `rr_ptr`.
- Output register update:
  - On load with a transfer: `out_data`, `out_last` and `out_sel` take the winning channel's values, and `out_valid` goes to 1.
  - On load with no transfer: `out_valid` goes to 0, and data, last and sel are held.
- Valid inputs of a non-selected channel may change freely. The block never drops or duplicates a beat.
- Reset (any time, including mid-packet): `out_valid`=0, `out_data`=0, `out_last`=0, `out_sel`=0, state ARB, `rr_ptr`=0. Any partial packet is abandoned. `in_ready` is all 0 while `rst_n`=0.

## Timing
- Input→output latency: 1 cycle. A beat accepted at edge k is visible on the `out_*` ports after edge k.
- Throughput: 1 beat/cycle while `out_ready`=1.
- `in_ready` depends combinationally on `out_ready`, `out_valid`, `in_valid` and state. There is no combinational path from `in_data` to `out_*`.
- Backpressure: while `out_valid && !out_ready`, all `out_*` are stable and all `in_ready`=0.
- Simultaneous last-beat and new requests: arbitration happens in the cycle after the last beat transfers. A new packet's first beat can therefore follow the previous last beat back-to-back only through ARB in the next cycle, giving at most one bubble per packet boundary.
- Single-beat packets (`in_last`=1 on the first beat) never enter LOCK.

## Structure
- Package `stream_mux_pkg`:
  - state enum {ARB, LOCK}
  - MODE constants `MODE_FIXED`=0, `MODE_RR`=1
  - SEL_W helper function
- Sub-module `rr_arbiter`:
  - Parameters N and MODE.
  - Inputs: request vector, `rr_ptr`.
  - Outputs: one-hot grant, grant index, `any`.
  - Purely combinational.
- The top level holds the FSM, `rr_ptr`, the output register and the ready decode.

## Test plan
- Reset mid-packet: channel 1 locked, 2 of 4 beats sent, assert `rst_n`=0 → `out_valid`=0, `out_sel`=0, `in_ready`=0000. After release, a request from channel 3 is granted.
- Round-robin fairness (N=4, MODE=1): all four channels continuously valid with 1-beat packets, `out_ready`=1 → `out_sel` sequence 0,1,2,3,0,1…, with no channel starved.
- Packet lock: channel 2 sends 3 beats (0xA1, 0xA2, 0xA3, last on 0xA3) while channel 0 is valid throughout → `out_data` A1, A2, A3 with `out_sel`=2 contiguously, `in_ready[0]`=0 until after A3, then channel 0 is granted.
- Fixed priority (MODE=0): channels 1 and 3 both valid → channel 1 wins every arbitration until it idles.
- Backpressure: `out_ready`=0 for 5 cycles with beat 0x5C held → `out_data`=0x5C, `out_valid`=1 stable, all `in_ready`=0. Release → next beat follows with no loss or duplication.
- Wrap-around: `rr_ptr`=3, only channels 3 and 0 valid → channel 3 granted. After its last beat, `rr_ptr`=0 and channel 0 is granted next.
